wb_arbiter: RTL and testbench

// - Two-master Wishbone classic arbiter. Shares the single master port of the wishbone mux between the

---
 rtl/wb_arb_pkg.sv | 13 +
 rtl/wb_arb_timeout.sv | 27 ++
 rtl/wb_arbiter.sv | 100 ++++++++++
 tb/tb_wb_arbiter.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared FSM encoding and counter sizing for the two-master Wishbone arbiter.
package wb_arb_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN0  = 2'd1,
    ST_OWN1  = 2'd2,
    ST_ABORT = 2'd3
  } state_e;

  function automatic int cnt_w(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction
endpackage

// File: rtl/wb_arb_timeout.sv
// wb_arb_timeout: slave-ack watchdog; expire_o fires in the cycle the count reaches TIMEOUT-1 while still waiting.
module wb_arb_timeout
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);
  generate
    if (TIMEOUT == 0) begin : g_off
      assign expire_o = 1'b0;
    end else begin : g_on
      localparam int CW = cnt_w(TIMEOUT);
      logic [CW-1:0] cnt_q, cnt_d;
      always_comb cnt_d = clr_i ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
      end
      assign expire_o = en_i && (cnt_q == CW'(TIMEOUT - 1));
    end
  endgenerate
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: two-master Wishbone classic arbiter, round-robin grant locked for a whole cyc, with
// a watchdog that answers a dead slave with a synthetic ack.
module wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int          TIMEOUT      = 64,
  parameter logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF,
  parameter int          RESET_PRIO   = 0
) (
  input  logic        io_wbs_clk,
  input  logic        io_wbs_rst_n,
  input  logic [31:0] io_wbs_m0_adr,
  input  logic [31:0] io_wbs_m0_datwr,
  output logic [31:0] io_wbs_m0_datrd,
  input  logic        io_wbs_m0_we,
  input  logic [3:0]  io_wbs_m0_sel,
  input  logic        io_wbs_m0_stb,
  input  logic        io_wbs_m0_cyc,
  output logic        io_wbs_m0_ack,
  input  logic [31:0] io_wbs_m1_adr,
  input  logic [31:0] io_wbs_m1_datwr,
  output logic [31:0] io_wbs_m1_datrd,
  input  logic        io_wbs_m1_we,
  input  logic [3:0]  io_wbs_m1_sel,
  input  logic        io_wbs_m1_stb,
  input  logic        io_wbs_m1_cyc,
  output logic        io_wbs_m1_ack,
  output logic [31:0] io_wbs_adr,
  output logic [31:0] io_wbs_datwr,
  output logic        io_wbs_we,
  output logic [3:0]  io_wbs_sel,
  output logic        io_wbs_stb,
  output logic        io_wbs_cyc,
  input  logic [31:0] io_wbs_datrd,
  input  logic        io_wbs_ack,
  output logic [1:0]  grant,
  output logic        timeout
);
  state_e state_q, state_d;
  logic   owner_q, owner_d, ptr_q, ptr_d;
  logic   own, m_cyc, m_stb, expire, ack_out;

  assign own   = (state_q == ST_OWN0) || (state_q == ST_OWN1);
  assign m_cyc = owner_q ? io_wbs_m1_cyc : io_wbs_m0_cyc;
  assign m_stb = owner_q ? io_wbs_m1_stb : io_wbs_m0_stb;

  wb_arb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk_i    (io_wbs_clk),
    .rst_ni   (io_wbs_rst_n),
    .clr_i    (!own || io_wbs_ack),
    .en_i     (own && m_stb && !io_wbs_ack),
    .expire_o (expire)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      ST_IDLE: if (io_wbs_m0_cyc || io_wbs_m1_cyc) begin
        owner_d = (io_wbs_m0_cyc && io_wbs_m1_cyc) ? ptr_q : io_wbs_m1_cyc;
        ptr_d   = !owner_d;
        state_d = owner_d ? ST_OWN1 : ST_OWN0;
      end
      ST_OWN0, ST_OWN1: state_d = !m_cyc ? ST_IDLE : expire ? ST_ABORT : state_q;
      ST_ABORT: state_d = m_cyc ? ST_ABORT : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge io_wbs_clk or negedge io_wbs_rst_n) begin
    if (!io_wbs_rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      ptr_q   <= 1'(RESET_PRIO);
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  // Slave side only sees the owner while in OWNx; ABORT isolates the dead slave.
  assign io_wbs_cyc   = own && m_cyc;
  assign io_wbs_stb   = own && m_stb;
  assign io_wbs_adr   = !own ? '0 : owner_q ? io_wbs_m1_adr   : io_wbs_m0_adr;
  assign io_wbs_datwr = !own ? '0 : owner_q ? io_wbs_m1_datwr : io_wbs_m0_datwr;
  assign io_wbs_we    = own && (owner_q ? io_wbs_m1_we : io_wbs_m0_we);
  assign io_wbs_sel   = !own ? '0 : owner_q ? io_wbs_m1_sel   : io_wbs_m0_sel;

  assign ack_out         = own && (io_wbs_ack || expire);
  assign io_wbs_m0_ack   = ack_out && !owner_q;
  assign io_wbs_m1_ack   = ack_out && owner_q;
  assign io_wbs_m0_datrd = (own && !owner_q) ? (expire ? TIMEOUT_DATA : io_wbs_datrd) : '0;
  assign io_wbs_m1_datrd = (own && owner_q)  ? (expire ? TIMEOUT_DATA : io_wbs_datrd) : '0;
  assign timeout         = expire;

  assign grant = {(state_q == ST_OWN1) || (state_q == ST_ABORT && owner_q),
                  (state_q == ST_OWN0) || (state_q == ST_ABORT && !owner_q)};
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed vector table for arbitration/lock plus hand sequences for timeout, race and async reset.
module tb_wb_arbiter;
  localparam logic [31:0] A0 = 32'h3000_0004;
  localparam logic [31:0] A1 = 32'h3000_1000;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] m0_datrd, m1_datrd, s_adr, s_datwr, s_datrd;
  logic        m0_stb, m0_cyc, m0_ack, m1_stb, m1_cyc, m1_ack;
  logic        s_we, s_stb, s_cyc, s_ack, to;
  logic [3:0]  s_sel;
  logic [1:0]  gnt;
  int          checks = 0, errors = 0;

  typedef struct {
    logic c0, s0, c1, s1, ack;
    logic [31:0] rd;
    logic [1:0]  gnt;
    logic        scyc;
    logic [31:0] adr;
    logic        a0, a1;
    logic [31:0] d0, d1;
  } vec_t;
  vec_t tbl[18];

  always #5 clk = ~clk;

  wb_arbiter #(.TIMEOUT(8), .TIMEOUT_DATA(32'hDEAD_BEEF), .RESET_PRIO(0)) dut (
    .io_wbs_clk(clk), .io_wbs_rst_n(rst_n),
    .io_wbs_m0_adr(A0), .io_wbs_m0_datwr(32'h0000_00A0), .io_wbs_m0_datrd(m0_datrd),
    .io_wbs_m0_we(1'b0), .io_wbs_m0_sel(4'hF), .io_wbs_m0_stb(m0_stb), .io_wbs_m0_cyc(m0_cyc),
    .io_wbs_m0_ack(m0_ack),
    .io_wbs_m1_adr(A1), .io_wbs_m1_datwr(32'h0000_00A1), .io_wbs_m1_datrd(m1_datrd),
    .io_wbs_m1_we(1'b1), .io_wbs_m1_sel(4'h3), .io_wbs_m1_stb(m1_stb), .io_wbs_m1_cyc(m1_cyc),
    .io_wbs_m1_ack(m1_ack),
    .io_wbs_adr(s_adr), .io_wbs_datwr(s_datwr), .io_wbs_we(s_we), .io_wbs_sel(s_sel),
    .io_wbs_stb(s_stb), .io_wbs_cyc(s_cyc), .io_wbs_datrd(s_datrd), .io_wbs_ack(s_ack),
    .grant(gnt), .timeout(to)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic c0, s0, c1, s1, ack, input logic [31:0] rd);
    m0_cyc = c0; m0_stb = s0; m1_cyc = c1; m1_stb = s1; s_ack = ack; s_datrd = rd;
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic step(input logic c0, s0, c1, s1, ack, input logic [31:0] rd);
    @(posedge clk);
    #1 drive(c0, s0, c1, s1, ack, rd);
    @(negedge clk);
  endtask

  initial begin
    tbl[0]  = '{1,1,1,1,0,32'h0,           2'b00,0,32'h0,0,0,32'h0,32'h0};
    tbl[1]  = '{1,1,1,1,0,32'h0,           2'b01,1,A0,  0,0,32'h0,32'h0};
    tbl[2]  = '{1,1,1,1,1,32'hA1A1_A1A1,   2'b01,1,A0,  1,0,32'hA1A1_A1A1,32'h0};
    tbl[3]  = '{0,0,0,0,0,32'h0,           2'b01,0,A0,  0,0,32'h0,32'h0};
    tbl[4]  = '{1,1,1,1,0,32'h0,           2'b00,0,32'h0,0,0,32'h0,32'h0};
    tbl[5]  = '{1,1,1,1,0,32'h0,           2'b10,1,A1,  0,0,32'h0,32'h0};
    tbl[6]  = '{1,1,1,1,1,32'hB2B2_B2B2,   2'b10,1,A1,  0,1,32'h0,32'hB2B2_B2B2};
    tbl[7]  = '{1,1,1,0,0,32'h0,           2'b10,1,A1,  0,0,32'h0,32'h0};
    tbl[8]  = '{1,1,1,1,0,32'h0,           2'b10,1,A1,  0,0,32'h0,32'h0};
    tbl[9]  = '{1,1,1,1,1,32'hB3B3_B3B3,   2'b10,1,A1,  0,1,32'h0,32'hB3B3_B3B3};
    tbl[10] = '{1,1,1,1,1,32'hB4B4_B4B4,   2'b10,1,A1,  0,1,32'h0,32'hB4B4_B4B4};
    tbl[11] = '{1,1,0,0,0,32'h0,           2'b10,0,A1,  0,0,32'h0,32'h0};
    tbl[12] = '{1,1,0,0,0,32'h0,           2'b00,0,32'h0,0,0,32'h0,32'h0};
    tbl[13] = '{1,1,0,0,0,32'h0,           2'b01,1,A0,  0,0,32'h0,32'h0};
    tbl[14] = '{1,1,0,0,0,32'h0,           2'b01,1,A0,  0,0,32'h0,32'h0};
    tbl[15] = '{1,1,0,0,1,32'h1234_5678,   2'b01,1,A0,  1,0,32'h1234_5678,32'h0};
    tbl[16] = '{0,0,0,0,0,32'h0,           2'b01,0,A0,  0,0,32'h0,32'h0};
    tbl[17] = '{0,0,0,0,0,32'h0,           2'b00,0,32'h0,0,0,32'h0,32'h0};

    drive(0, 0, 0, 0, 0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst grant", gnt, 2'b00);
    chk("rst s_cyc", s_cyc, 0);
    chk("rst acks", {m0_ack, m1_ack, to}, 3'b000);
    chk("rst datrd", m0_datrd | m1_datrd, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      step(tbl[i].c0, tbl[i].s0, tbl[i].c1, tbl[i].s1, tbl[i].ack, tbl[i].rd);
      chk($sformatf("v%0d grant", i), gnt, tbl[i].gnt);
      chk($sformatf("v%0d s_cyc", i), s_cyc, tbl[i].scyc);
      chk($sformatf("v%0d s_adr", i), s_adr, tbl[i].adr);
      chk($sformatf("v%0d m0_ack", i), m0_ack, tbl[i].a0);
      chk($sformatf("v%0d m1_ack", i), m1_ack, tbl[i].a1);
      chk($sformatf("v%0d m0_datrd", i), m0_datrd, tbl[i].d0);
      chk($sformatf("v%0d m1_datrd", i), m1_datrd, tbl[i].d1);
      chk($sformatf("v%0d timeout", i), to, 0);
    end

    // Dead slave: synthetic ack on the 8th cycle the slave sees stb, then ABORT.
    step(1, 1, 0, 0, 0, 32'h0);
    chk("to idle grant", gnt, 2'b00);
    for (int k = 1; k < 8; k++) begin
      step(1, 1, 0, 0, 0, 32'h0);
      chk($sformatf("to wait%0d ack", k), m0_ack, 0);
      chk($sformatf("to wait%0d pulse", k), to, 0);
      chk($sformatf("to wait%0d s_stb", k), s_stb, 1);
    end
    step(1, 1, 0, 0, 0, 32'h0);
    chk("to expire ack", m0_ack, 1);
    chk("to expire pulse", to, 1);
    chk("to expire datrd", m0_datrd, 32'hDEAD_BEEF);
    chk("to expire m1_ack", m1_ack, 0);
    step(1, 1, 0, 0, 0, 32'h0);
    chk("abort s_cyc", s_cyc, 0);
    chk("abort s_stb", s_stb, 0);
    chk("abort grant", gnt, 2'b01);
    chk("abort ack", m0_ack, 0);
    chk("abort pulse", to, 0);
    step(1, 1, 0, 0, 1, 32'h1111_1111);
    chk("late ack dropped", m0_ack, 0);
    chk("late datrd dropped", m0_datrd, 32'h0);
    step(0, 0, 0, 0, 0, 32'h0);
    chk("abort hold grant", gnt, 2'b01);
    step(0, 0, 0, 0, 0, 32'h0);
    chk("abort exit grant", gnt, 2'b00);

    // Slave ack on the expiry cycle wins over the timeout.
    step(0, 0, 1, 1, 0, 32'h0);
    chk("race idle grant", gnt, 2'b00);
    for (int k = 1; k < 8; k++) begin
      step(0, 0, 1, 1, 0, 32'h0);
      chk($sformatf("race wait%0d ack", k), m1_ack, 0);
    end
    step(0, 0, 1, 1, 1, 32'h5A5A_5A5A);
    chk("race ack", m1_ack, 1);
    chk("race datrd", m1_datrd, 32'h5A5A_5A5A);
    chk("race pulse", to, 0);
    step(0, 0, 1, 1, 0, 32'h0);
    chk("race no abort grant", gnt, 2'b10);
    chk("race no abort s_cyc", s_cyc, 1);
    step(0, 0, 0, 0, 0, 32'h0);
    step(0, 0, 0, 0, 0, 32'h0);
    chk("race end grant", gnt, 2'b00);

    // Asynchronous reset in the middle of an owned transfer.
    step(1, 1, 0, 0, 0, 32'h0);
    step(1, 1, 0, 0, 0, 32'h0);
    chk("pre-rst grant", gnt, 2'b01);
    chk("pre-rst s_cyc", s_cyc, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst grant", gnt, 2'b00);
    chk("async rst s_cyc", s_cyc, 0);
    chk("async rst s_stb", s_stb, 0);
    chk("async rst s_adr", s_adr, 32'h0);
    @(posedge clk);
    #1 begin rst_n = 1'b1; drive(0, 0, 0, 0, 0, 32'h0); end
    @(negedge clk);
    chk("post-rst grant", gnt, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
